// File: rtl/ttt_move_controller.sv
// Tic-tac-toe move controller: cursor navigation, mark placement, win/draw detection.
// Define TTT_CURSOR_WRAP_EN to make cursor moves wrap within a row/column instead of saturating.
module ttt_move_controller #(
   parameter logic FIRST_PLAYER = 1'b0
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       ack_i,
   input  logic       lbtn_i,
   input  logic       rbtn_i,
   input  logic       ubtn_i,
   input  logic       dbtn_i,
   input  logic       cbtn_i,
   output logic [3:0] cursor_o,
   output logic [8:0] board_x_o,
   output logic [8:0] board_o_o,
   output logic       turn_o,
   output logic [3:0] move_cnt_o,
   output logic       illegal_o,
   output logic       xwins_o,
   output logic       owins_o,
   output logic       draw_o,
   output logic       qi_o,
   output logic       qp_o,
   output logic       qc_o,
   output logic       qd_o
);

`ifdef TTT_CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_PLAY  = 4'b0010,
      S_CHECK = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   state_t     state_q;
   logic [3:0] cursor_q, cursor_d;
   logic [8:0] bx_q, bo_q;
   logic       turn_q;
   logic [3:0] cnt_q;
   logic       illegal_q, xw_q, ow_q, dr_q;
   logic       win_d, new_round_d;

   function automatic logic [1:0] col_of(input logic [3:0] c);
      case (c)
         4'd0, 4'd3, 4'd6: col_of = 2'd0;
         4'd1, 4'd4, 4'd7: col_of = 2'd1;
         default:          col_of = 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] row_of(input logic [3:0] c);
      if (c < 4'd3)      row_of = 2'd0;
      else if (c < 4'd6) row_of = 2'd1;
      else               row_of = 2'd2;
   endfunction

   function automatic logic has_line(input logic [8:0] b);
      has_line = (&{b[0], b[1], b[2]}) | (&{b[3], b[4], b[5]}) | (&{b[6], b[7], b[8]}) |
                 (&{b[0], b[3], b[6]}) | (&{b[1], b[4], b[7]}) | (&{b[2], b[5], b[8]}) |
                 (&{b[0], b[4], b[8]}) | (&{b[2], b[4], b[6]});
   endfunction

   // Cursor target for the highest-priority direction button; Cbtn is resolved in the FSM.
   always_comb begin
      cursor_d = cursor_q;
      if (lbtn_i) begin
         if (col_of(cursor_q) != 2'd0) cursor_d = cursor_q - 4'd1;
         else if (WRAP)                cursor_d = cursor_q + 4'd2;
      end else if (rbtn_i) begin
         if (col_of(cursor_q) != 2'd2) cursor_d = cursor_q + 4'd1;
         else if (WRAP)                cursor_d = cursor_q - 4'd2;
      end else if (ubtn_i) begin
         if (row_of(cursor_q) != 2'd0) cursor_d = cursor_q - 4'd3;
         else if (WRAP)                cursor_d = cursor_q + 4'd6;
      end else if (dbtn_i) begin
         if (row_of(cursor_q) != 2'd2) cursor_d = cursor_q + 4'd3;
         else if (WRAP)                cursor_d = cursor_q - 4'd6;
      end
   end

   assign win_d       = has_line(turn_q ? bo_q : bx_q);
   assign new_round_d = ((state_q == S_IDLE) && start_i) ||
                        ((state_q == S_DONE) && !ack_i && cbtn_i);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cursor_q  <= 4'd4;
         bx_q      <= '0;
         bo_q      <= '0;
         turn_q    <= FIRST_PLAYER;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         xw_q      <= 1'b0;
         ow_q      <= 1'b0;
         dr_q      <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start_i) state_q <= S_PLAY;
            S_PLAY: begin
               if (cbtn_i) begin
                  if (bx_q[cursor_q] || bo_q[cursor_q]) begin
                     illegal_q <= 1'b1;
                  end else begin
                     if (turn_q) bo_q[cursor_q] <= 1'b1;
                     else        bx_q[cursor_q] <= 1'b1;
                     cnt_q   <= cnt_q + 4'd1;
                     state_q <= S_CHECK;
                  end
               end else begin
                  cursor_q <= cursor_d;
               end
            end
            S_CHECK: begin
               if (win_d) begin
                  if (turn_q) ow_q <= 1'b1;
                  else        xw_q <= 1'b1;
                  state_q <= S_DONE;
               end else if (cnt_q == 4'd9) begin
                  dr_q    <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  turn_q  <= ~turn_q;
                  state_q <= S_PLAY;
               end
            end
            S_DONE: begin
               if (ack_i)       state_q <= S_IDLE;
               else if (cbtn_i) state_q <= S_PLAY;
            end
            default: state_q <= S_IDLE;
         endcase
         // Round start from IDLE or DONE overrides the per-state updates above.
         if (new_round_d) begin
            cursor_q <= 4'd4;
            bx_q     <= '0;
            bo_q     <= '0;
            turn_q   <= FIRST_PLAYER;
            cnt_q    <= '0;
            xw_q     <= 1'b0;
            ow_q     <= 1'b0;
            dr_q     <= 1'b0;
         end
      end
   end

   assign cursor_o   = cursor_q;
   assign board_x_o  = bx_q;
   assign board_o_o  = bo_q;
   assign turn_o     = turn_q;
   assign move_cnt_o = cnt_q;
   assign illegal_o  = illegal_q;
   assign xwins_o    = xw_q;
   assign owins_o    = ow_q;
   assign draw_o     = dr_q;
   assign qi_o       = state_q[0];
   assign qp_o       = state_q[1];
   assign qc_o       = state_q[2];
   assign qd_o       = state_q[3];

endmodule

// File: doc/ttt_move_controller.md
TTT_MOVE_CONTROLLER -- requirements
Module: ttt_move_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 0; player who moves first in every round (0 = X, 1 = O).
REQ-002 Clk  input  1  system clock; all logic on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  level; begins a new game from IDLE.
REQ-005 Ack  input  1  level; returns from DONE to IDLE.
REQ-006 Lbtn, Rbtn, Ubtn, Dbtn, Cbtn  input  1 each  single-cycle debounced button pulses.
REQ-007 Cursor  output  4  selected cell index, 0..8, row-major.
REQ-008 BoardX  output  9  bit i = 1 when cell i holds X.
REQ-009 BoardO  output  9  bit i = 1 when cell i holds O.
REQ-010 Turn  output  1  player to move (0 = X, 1 = O).
REQ-011 MoveCnt  output  4  moves placed this round, 0..9.
REQ-012 Illegal  output  1  one-cycle pulse on a rejected Cbtn.
REQ-013 Xwins, Owins, Draw  output  1 each  round result flags.
REQ-014 Qi, Qp, Qc, Qd  output  1 each  one-hot state: IDLE, PLAY, CHECK, DONE.

Function
REQ-015 States are IDLE, PLAY, CHECK and DONE, one-hot encoded, with exactly one state active at all times after reset.
REQ-016 IDLE: Start=1 -> clear the board, set MoveCnt=0, Cursor=4, Turn=FIRST_PLAYER, clear the result flags, and go to PLAY on the next edge.
REQ-017 PLAY acts on at most one button per cycle, priority Cbtn > Lbtn > Rbtn > Ubtn > Dbtn; lower-priority buttons asserted in the same cycle are ignored.
REQ-018 PLAY, Cbtn on an empty cell -> set bit Cursor of BoardX (Turn=0) or BoardO (Turn=1), MoveCnt+1, go to CHECK.
REQ-019 PLAY, Cbtn on an occupied cell -> board, MoveCnt and Turn unchanged; Illegal=1 for exactly one cycle; stay in PLAY.
REQ-020 Lbtn/Rbtn move the cursor by -1/+1 within its row; Ubtn/Dbtn move it by -3/+3 within its column; edge behaviour per REQ-031.
REQ-021 CHECK lasts exactly one cycle and evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the board of the player who just moved.
REQ-022 CHECK, line complete -> set Xwins or Owins for the mover, go to DONE.
REQ-023 CHECK, no line complete and MoveCnt=9 -> Draw=1, go to DONE; a win on the 9th move takes precedence over Draw.
REQ-024 CHECK, otherwise -> invert Turn, return to PLAY; buttons are ignored while in CHECK.
REQ-025 The latency from an accepted Cbtn to a visible result flag or Turn change is 2 edges.
REQ-026 DONE holds the board, the flags and MoveCnt; Ack=1 -> IDLE; else Cbtn=1 -> new round as in REQ-016, straight to PLAY; Ack takes priority over Cbtn.
REQ-027 Xwins, Owins and Draw are mutually exclusive and change only in CHECK, or when cleared on round start or reset.

Reset
REQ-028 Reset=1 at any edge, in any state including mid-CHECK, forces state IDLE on that edge and overrides all other inputs.
REQ-029 Reset values: BoardX=BoardO=0, MoveCnt=0, Cursor=4, Turn=FIRST_PLAYER, Illegal=Xwins=Owins=Draw=0, Qi=1, Qp=Qc=Qd=0.
REQ-030 No register holds an undefined value after reset.

Configuration
REQ-031 Macro TTT_CURSOR_WRAP_EN: when defined, cursor moves wrap within the row or column (0 + Lbtn -> 2, 6 + Dbtn -> 0); when undefined, the cursor saturates at the edge (0 + Lbtn -> 0, 8 + Dbtn -> 8).

Verification
REQ-032 Reset, Start, then Cbtn x5 alternating with cursor moves to place X@0, O@3, X@1, O@4, X@2 -> Xwins=1 two edges after the 5th Cbtn; Qd=1; MoveCnt=5.
REQ-033 Cell 4 holds X; O presses Cbtn at Cursor=4 -> Illegal pulse of exactly one cycle; BoardO, MoveCnt and Turn unchanged.
REQ-034 Nine-move sequence X0, O1, X2, O4, X3, O5, X7, O6, X8, which completes no line -> Draw=1, Xwins=Owins=0, MoveCnt=9.
REQ-035 Cbtn and Rbtn asserted together at Cursor=4 on an empty cell -> the mark is placed at 4 and Cursor stays 4.
REQ-036 Cursor=2 with Rbtn: with TTT_CURSOR_WRAP_EN defined -> Cursor=0; without it -> Cursor=2.
REQ-037 Reset asserted in the CHECK cycle -> next state IDLE with all REQ-029 values; a subsequent Ack or Cbtn in IDLE has no effect.
